fmul_iter: RTL and testbench

Parametrised, iterative floating-point multiplier for the processor's multi-cycle execute path. It multiplies two IEEE-754-style operands of configurable exponent and mantissa width using a one-bit-per-cycle shift-add significand datapath. It handles specials, normalises, rounds and reports exception flags. It is started by the control unit the same way as the other multi-cycle units (Start/Busy/Done), and it replaces the fixed 32-bit combinational-special-case multiplier.

---
 rtl/fmul_iter.sv | 203 ++++++++++++++++++++
 tb/tb_fmul_iter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fmul_iter.sv
// Iterative IEEE-754-style multiplier: shift-add significand datapath, specials, normalise, round, flags.
// Define FMUL_ITER_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fmul_iter #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         CLK,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [W-1:0] Operand1,
    input  logic [W-1:0] Operand2,
    output logic [W-1:0] Result,
    output logic [3:0]   Flags,
    output logic         Busy,
    output logic         Done
);
    localparam int SW  = MAN_W + 1;
    localparam int PW  = 2 * SW;
    localparam int CW  = $clog2(MAN_W + 1);
    localparam int EW2 = EXP_W + 2;
    localparam logic [EW2-1:0] BIAS_C     = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW2-1:0] EMAX_C     = EW2'((1 << EXP_W) - 1);
    localparam logic [CW-1:0]  CNT_INIT_C = CW'(MAN_W);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SPEC = 3'd1,
        ST_MUL  = 3'd2,
        ST_NORM = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic is_special(input logic [EXP_W-1:0] ea, input logic [EXP_W-1:0] eb);
        return (ea == '0) || (eb == '0) || (&ea) || (&eb);
    endfunction

    // Returns {result, flags}; subnormals (exp==0) are treated as signed zero.
    function automatic logic [W+3:0] special_out(input logic sign,
                                                 input logic [EXP_W-1:0] ea, input logic [MAN_W-1:0] ma,
                                                 input logic [EXP_W-1:0] eb, input logic [MAN_W-1:0] mb);
        logic nan_a, nan_b, inf_a, inf_b, inv;
        logic [W+3:0] r;
        nan_a = (&ea) & (|ma);
        nan_b = (&eb) & (|mb);
        inf_a = (&ea) & ~(|ma);
        inf_b = (&eb) & ~(|mb);
        inv   = (inf_a & (eb == '0)) | (inf_b & (ea == '0));
        if (nan_a | nan_b | inv) begin
            r = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}, inv, 3'b000};
        end else if (inf_a | inf_b) begin
            r = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}, 4'b0000};
        end else begin
            r = {sign, {(EXP_W+MAN_W){1'b0}}, 4'b0000};
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   e1_q, e1_d, e2_q, e2_d;
    logic [PW-1:0]      mcand_q, mcand_d, acc_q, acc_d;
    logic [SW-1:0]      mplier_q, mplier_d;
    logic [W-1:0]       result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               accept_s, msb_s, guard_s, sticky_s, inc_s, ovf_s, unf_s;
    logic [PW-2:0]      norm_s;
    logic [MAN_W-1:0]   man_s;
    logic [MAN_W:0]     man_rnd_s;
    logic [EW2-1:0]     exp_s, exp_r_s;

    // Normalise, round and range-check the finished product.
    always_comb begin
        msb_s     = acc_q[PW-1];
        norm_s    = msb_s ? acc_q[PW-2:0] : {acc_q[PW-3:0], 1'b0};
        man_s     = norm_s[2*MAN_W -: MAN_W];
        guard_s   = norm_s[MAN_W];
        sticky_s  = |norm_s[MAN_W-1:0];
`ifdef FMUL_ITER_RNE_EN
        inc_s     = guard_s & (sticky_s | man_s[0]);
`else
        inc_s     = 1'b0;
`endif
        man_rnd_s = {1'b0, man_s} + {{MAN_W{1'b0}}, inc_s};
        exp_s     = {2'b00, e1_q} + {2'b00, e2_q} - BIAS_C + {{(EW2-1){1'b0}}, msb_s};
        exp_r_s   = exp_s + {{(EW2-1){1'b0}}, man_rnd_s[MAN_W]};
        ovf_s     = ~exp_r_s[EW2-1] & (exp_r_s >= EMAX_C);
        unf_s     = exp_r_s[EW2-1] | (exp_r_s == '0);
    end

    // Control FSM and datapath next-state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        e1_d     = e1_q;
        e2_d     = e2_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        flags_d  = flags_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        accept_s = Start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    sign_d   = Operand1[W-1] ^ Operand2[W-1];
                    e1_d     = Operand1[W-2 -: EXP_W];
                    e2_d     = Operand2[W-2 -: EXP_W];
                    mcand_d  = {{(PW-SW){1'b0}}, 1'b1, Operand1[MAN_W-1:0]};
                    mplier_d = {1'b1, Operand2[MAN_W-1:0]};
                    acc_d    = '0;
                    cnt_d    = CNT_INIT_C;
                    busy_d   = 1'b1;
                    state_d  = is_special(Operand1[W-2 -: EXP_W], Operand2[W-2 -: EXP_W]) ? ST_SPEC : ST_MUL;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SPEC: begin
                {result_d, flags_d} = special_out(sign_q, e1_q, mcand_q[MAN_W-1:0], e2_q, mplier_q[MAN_W-1:0]);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_DONE;
            end
            ST_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_NORM: begin
                if (ovf_s) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d  = 4'b0101;
                end else if (unf_s) begin
                    result_d = {sign_q, {(EXP_W+MAN_W){1'b0}}};
                    flags_d  = 4'b0011;
                end else begin
                    result_d = {sign_q, exp_r_s[EXP_W-1:0], man_rnd_s[MAN_W-1:0]};
                    flags_d  = {3'b000, guard_s | sticky_s};
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            e1_q     <= '0;
            e2_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            flags_q  <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            e1_q     <= e1_d;
            e2_q     <= e2_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Result = result_q;
    assign Flags  = flags_q;
    assign Busy   = busy_q;
    assign Done   = done_q;
endmodule

// File: tb/tb_fmul_iter.sv
// Directed scoreboard bench for fmul_iter at default widths (EXP_W=8, MAN_W=23).
module tb_fmul_iter;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int LAT   = MAN_W + 2;

    logic         CLK = 1'b0;
    logic         Reset_n;
    logic         Start;
    logic [W-1:0] Operand1, Operand2, Result;
    logic [3:0]   Flags;
    logic         Busy, Done;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flg;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    fmul_iter #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result   (Result),
        .Flags    (Flags),
        .Busy     (Busy),
        .Done     (Done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] er, input logic [3:0] ef);
        exp_t e;
        e.res = er;
        e.flg = ef;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic go();
        @(posedge CLK);
        #1;
        Start    = 1'b0;
        Operand1 = $urandom;
        Operand2 = $urandom;
    endtask

    task automatic wait_done(input string tag, input int elat, input bit noise);
        int   lat;
        int   busy_n;
        exp_t e;
        lat    = 0;
        busy_n = 0;
        while (Done !== 1'b1 && lat < 200) begin
            if (Busy === 1'b1) busy_n++;
            if (noise) Start = (lat >= 2 && lat < 6);
            @(posedge CLK);
            #1;
            lat++;
        end
        Start = 1'b0;
        check({tag, ".done_seen"}, 64'(Done), 64'(1'b1));
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".busy_cycles"}, 64'(busy_n), 64'(elat));
        check({tag, ".busy_at_done"}, 64'(Busy), 64'(1'b0));
        check({tag, ".sb_nonempty"}, 64'(sb_q.size() != 0), 64'(1'b1));
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, ".result"}, 64'(Result), 64'(e.res));
            check({tag, ".flags"}, 64'(Flags), 64'(e.flg));
        end
    endtask

    task automatic idle(input string tag);
        @(posedge CLK);
        #1;
        check({tag, ".done_pulse"}, 64'(Done), 64'(1'b0));
        check({tag, ".busy_idle"}, 64'(Busy), 64'(1'b0));
    endtask

    initial begin
        int dn;
        Reset_n  = 1'b1;
        Start    = 1'b0;
        Operand1 = '0;
        Operand2 = '0;
        #2;
        Reset_n = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset.result", 64'(Result), 64'(0));
        check("reset.flags", 64'(Flags), 64'(0));
        check("reset.busy", 64'(Busy), 64'(0));
        check("reset.done", 64'(Done), 64'(0));
        Reset_n = 1'b1;
        @(posedge CLK);
        #1;

        start_op(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000); go(); wait_done("mul3x2", LAT, 1'b0); idle("mul3x2");
        start_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000); go(); wait_done("norm_shift", LAT, 1'b0); idle("norm_shift");
`ifdef FMUL_ITER_RNE_EN
        start_op(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
`else
        start_op(32'h3F800001, 32'h3FC00000, 32'h3FC00001, 4'b0001);
`endif
        go(); wait_done("round_tie", LAT, 1'b0); idle("round_tie");
        start_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001); go(); wait_done("sticky_only", LAT, 1'b0); idle("sticky_only");
        start_op(32'hC0400000, 32'h40000000, 32'hC0C00000, 4'b0000); go(); wait_done("neg_sign", LAT, 1'b0); idle("neg_sign");
        start_op(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101); go(); wait_done("overflow", LAT, 1'b0); idle("overflow");
        start_op(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011); go(); wait_done("underflow", LAT, 1'b0); idle("underflow");
        start_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000); go(); wait_done("inf_x_zero", 1, 1'b0); idle("inf_x_zero");
        start_op(32'h7FC12345, 32'h3F800000, 32'h7FC00000, 4'b0000); go(); wait_done("nan_in", 1, 1'b0); idle("nan_in");
        start_op(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000); go(); wait_done("neg_inf", 1, 1'b0); idle("neg_inf");
        start_op(32'h00400000, 32'hC0000000, 32'h80000000, 4'b0000); go(); wait_done("subnormal_flush", 1, 1'b0); idle("subnormal_flush");

        start_op(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000); go(); wait_done("b2b_first", LAT, 1'b0);
        start_op(32'hC0400000, 32'h40000000, 32'hC0C00000, 4'b0000); go(); wait_done("b2b_second", LAT, 1'b0); idle("b2b_second");

        start_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000); go(); wait_done("start_while_busy", LAT, 1'b1); idle("start_while_busy");

        start_op(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000); go();
        repeat (10) @(posedge CLK);
        #1;
        Reset_n = 1'b0;
        #1;
        check("midreset.result", 64'(Result), 64'(0));
        check("midreset.flags", 64'(Flags), 64'(0));
        check("midreset.busy", 64'(Busy), 64'(0));
        check("midreset.done", 64'(Done), 64'(0));
        void'(sb_q.pop_front());
        @(negedge CLK);
        Reset_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (Done === 1'b1) dn++;
        end
        check("midreset.no_done", 64'(dn), 64'(0));
        check("midreset.busy_after", 64'(Busy), 64'(0));

        start_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000); go(); wait_done("recover", 1, 1'b0); idle("recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
